// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, datapath sizes and control encodings
// used by the ID stage and its register file.
package riscv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file: 2 combinational read ports, 1 write port,
// write-through on same-cycle read/write collisions, x0 hard-wired to zero.
module register_file
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int IDXW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] ra1,
    input  logic [IDXW-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [IDXW-1:0] wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];
    logic            writeLive;

    assign writeLive = we && (wa != {IDXW{1'b0}});

    // Register storage: synchronous clear on reset, otherwise a single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= {XLEN{1'b0}};
            end
        end else if (writeLive) begin
            regs[wa] <= wd;
        end else begin
            regs[wa] <= regs[wa];
        end
    end

    // Read port 1 with x0 forced to zero and write-through bypass.
    always_comb begin
        rd1 = {XLEN{1'b0}};
        if (ra1 == {IDXW{1'b0}}) begin
            rd1 = {XLEN{1'b0}};
        end else if (writeLive && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs[ra1];
        end
    end

    // Read port 2 with x0 forced to zero and write-through bypass.
    always_comb begin
        rd2 = {XLEN{1'b0}};
        if (ra2 == {IDXW{1'b0}}) begin
            rd2 = {XLEN{1'b0}};
        end else if (writeLive && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs[ra2];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I instruction decode stage: control decode, register read, immediate extend
// and the ID/EX pipeline register. Optional illegal-opcode flag: DECODE_ILLEGAL_TRAP_EN.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    input  logic            StallE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            IllegalE
`endif
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rdD;

    logic        regWriteD;
    logic        memWriteD;
    logic        jumpD;
    logic        branchD;
    logic        aluSrcD;
    logic        aluUseFunct;
    logic        isRtype;
    logic        illegalD;
    result_src_t resultSrcD;
    imm_src_t    immSrcD;
    alu_ctrl_t   aluFixed;
    alu_ctrl_t   aluFunct;
    alu_ctrl_t   aluCtrlD;
    logic [XLEN-1:0] immExtD;
    logic [XLEN-1:0] rd1D;
    logic [XLEN-1:0] rd2D;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rs1D     = InstrD[19:15];
    assign rs2D     = InstrD[24:20];
    assign rdD      = InstrD[11:7];

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .IDXW  (5)
    ) u_register_file (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1D),
        .ra2 (rs2D),
        .rd1 (rd1D),
        .rd2 (rd2D),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW)
    );

    // Main control decode by opcode; anything unsupported becomes a nop.
    always_comb begin
        regWriteD   = 1'b0;
        memWriteD   = 1'b0;
        jumpD       = 1'b0;
        branchD     = 1'b0;
        aluSrcD     = 1'b0;
        aluUseFunct = 1'b0;
        isRtype     = 1'b0;
        illegalD    = 1'b0;
        resultSrcD  = RES_ALU;
        immSrcD     = IMM_I;
        aluFixed    = ALU_ADD;
        case (opcode)
            OP_LW: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = RES_MEM;
                immSrcD    = IMM_I;
            end
            OP_SW: begin
                memWriteD = 1'b1;
                aluSrcD   = 1'b1;
                immSrcD   = IMM_S;
            end
            OP_RTYPE: begin
                regWriteD   = 1'b1;
                aluUseFunct = 1'b1;
                isRtype     = 1'b1;
            end
            OP_IALU: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                immSrcD     = IMM_I;
                aluUseFunct = 1'b1;
            end
            OP_BEQ: begin
                branchD  = 1'b1;
                aluFixed = ALU_SUB;
                immSrcD  = IMM_B;
            end
            OP_JAL: begin
                jumpD      = 1'b1;
                regWriteD  = 1'b1;
                resultSrcD = RES_PC4;
                immSrcD    = IMM_J;
            end
            default: begin
                illegalD = 1'b1;
            end
        endcase
    end

    // ALU operation from funct3 / funct7[5]; sub only exists for R-type.
    always_comb begin
        aluFunct = ALU_ADD;
        case (funct3)
            3'b000: begin
                if (isRtype && funct7b5) begin
                    aluFunct = ALU_SUB;
                end else begin
                    aluFunct = ALU_ADD;
                end
            end
            3'b010:  aluFunct = ALU_SLT;
            3'b110:  aluFunct = ALU_OR;
            3'b111:  aluFunct = ALU_AND;
            default: aluFunct = ALU_ADD;
        endcase
        if (aluUseFunct) begin
            aluCtrlD = aluFunct;
        end else begin
            aluCtrlD = aluFixed;
        end
    end

    // Immediate extender; InstrD[31] is the sign bit for every format.
    always_comb begin
        immExtD = {XLEN{1'b0}};
        case (immSrcD)
            IMM_I:   immExtD = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   immExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   immExtD = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   immExtD = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: immExtD = {XLEN{1'b0}};
        endcase
    end

    // ID/EX register: reset and flush clear everything, stall holds, otherwise load.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= {XLEN{1'b0}};
            RD2E        <= {XLEN{1'b0}};
            ImmExtE     <= {XLEN{1'b0}};
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= {XLEN{1'b0}};
            PCPlus4E    <= {XLEN{1'b0}};
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= 1'b0;
`endif
        end else if (!StallE) begin
            RegWriteE   <= regWriteD;
            MemWriteE   <= memWriteD;
            JumpE       <= jumpD;
            BranchE     <= branchD;
            ALUSrcE     <= aluSrcD;
            ResultSrcE  <= resultSrcD;
            ALUControlE <= aluCtrlD;
            RD1E        <= rd1D;
            RD2E        <= rd2D;
            ImmExtE     <= immExtD;
            Rs1E        <= rs1D;
            Rs2E        <= rs2D;
            RdE         <= rdD;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= illegalD || (InstrD[1:0] != 2'b11);
`endif
        end else begin
            RegWriteE   <= RegWriteE;
            MemWriteE   <= MemWriteE;
            JumpE       <= JumpE;
            BranchE     <= BranchE;
            ALUSrcE     <= ALUSrcE;
            ResultSrcE  <= ResultSrcE;
            ALUControlE <= ALUControlE;
            RD1E        <= RD1E;
            RD2E        <= RD2E;
            ImmExtE     <= ImmExtE;
            Rs1E        <= Rs1E;
            Rs2E        <= Rs2E;
            RdE         <= RdE;
            PCE         <= PCE;
            PCPlus4E    <= PCPlus4E;
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= IllegalE;
`endif
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle with hand-computed expectations.
// Define DECODE_ILLEGAL_TRAP_EN to also exercise IllegalE.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        StallE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        IllegalE;
`endif

    int compareCount;
    int mismatchCount;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .StallE      (StallE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .IllegalE    (IllegalE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction plus W-port activity, then clock it into ID/EX.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        RegWriteW = we;
        RDW       = wa;
        ResultW   = wd;
        @(posedge clk);
        #1;
        RegWriteW = 1'b0;
    endtask

    task automatic checkCtrl(input string tag, input logic [31:0] rw, input logic [31:0] mw,
                             input logic [31:0] jp, input logic [31:0] br);
        checkEq({tag, ".RegWriteE"}, {31'd0, RegWriteE}, rw);
        checkEq({tag, ".MemWriteE"}, {31'd0, MemWriteE}, mw);
        checkEq({tag, ".JumpE"},     {31'd0, JumpE},     jp);
        checkEq({tag, ".BranchE"},   {31'd0, BranchE},   br);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst       = 1'b1;
        FlushE    = 1'b0;
        StallE    = 1'b0;
        InstrD    = 32'h00500093;
        PCD       = 32'h0000_0040;
        PCPlus4D  = 32'h0000_0044;
        RegWriteW = 1'b0;
        RDW       = 5'd0;
        ResultW   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkCtrl("reset", 32'd0, 32'd0, 32'd0, 32'd0);
        checkEq("reset.ImmExtE", ImmExtE, 32'd0);
        checkEq("reset.RdE", {27'd0, RdE}, 32'd0);
        checkEq("reset.PCE", PCE, 32'd0);
        rst = 1'b0;

        // addi x1,x0,5 while writing x1=5 for later reads
        issue(32'h00500093, 32'h0000_0100, 1'b1, 5'd1, 32'd5);
        checkEq("addi.ImmExtE", ImmExtE, 32'd5);
        checkEq("addi.ALUSrcE", {31'd0, ALUSrcE}, 32'd1);
        checkEq("addi.RegWriteE", {31'd0, RegWriteE}, 32'd1);
        checkEq("addi.RdE", {27'd0, RdE}, 32'd1);
        checkEq("addi.ALUControlE", {29'd0, ALUControlE}, 32'd0);
        checkEq("addi.RD1E", RD1E, 32'd0);
        checkEq("addi.PCE", PCE, 32'h0000_0100);
        checkEq("addi.PCPlus4E", PCPlus4E, 32'h0000_0104);

        // add x3,x1,x2 with x2 written in the same cycle
        issue(32'h002081B3, 32'h0000_0104, 1'b1, 5'd2, 32'hDEADBEEF);
        checkEq("add.RD2E", RD2E, 32'hDEADBEEF);
        checkEq("add.Rs2E", {27'd0, Rs2E}, 32'd2);
        checkEq("add.RD1E", RD1E, 32'd5);
        checkEq("add.ALUSrcE", {31'd0, ALUSrcE}, 32'd0);
        checkEq("add.ALUControlE", {29'd0, ALUControlE}, 32'd0);

        // sub x4,x1,x2
        issue(32'h40208233, 32'h0000_0108, 1'b0, 5'd0, 32'd0);
        checkEq("sub.ALUControlE", {29'd0, ALUControlE}, 32'd1);
        checkEq("sub.RdE", {27'd0, RdE}, 32'd4);

        // or / and R-type
        issue(32'h0020E433, 32'h0000_010C, 1'b0, 5'd0, 32'd0);
        checkEq("or.ALUControlE", {29'd0, ALUControlE}, 32'd3);
        issue(32'h0020F433, 32'h0000_0110, 1'b0, 5'd0, 32'd0);
        checkEq("and.ALUControlE", {29'd0, ALUControlE}, 32'd2);

        // slti x7,x1,-1
        issue(32'hFFF0A393, 32'h0000_0114, 1'b0, 5'd0, 32'd0);
        checkEq("slti.ALUControlE", {29'd0, ALUControlE}, 32'd5);
        checkEq("slti.ImmExtE", ImmExtE, 32'hFFFFFFFF);

        // beq x0,x0,-4: B-immediate encodes -4
        issue(32'hFE000EE3, 32'h0000_0118, 1'b0, 5'd0, 32'd0);
        checkCtrl("beq", 32'd0, 32'd0, 32'd0, 32'd1);
        checkEq("beq.ImmExtE", ImmExtE, 32'hFFFFFFFC);
        checkEq("beq.ALUControlE", {29'd0, ALUControlE}, 32'd1);

        // sw x2,12(x1) and sw x2,-4(x1)
        issue(32'h0020A623, 32'h0000_011C, 1'b0, 5'd0, 32'd0);
        checkCtrl("sw", 32'd0, 32'd1, 32'd0, 32'd0);
        checkEq("sw.ImmExtE", ImmExtE, 32'd12);
        checkEq("sw.RD2E", RD2E, 32'hDEADBEEF);
        issue(32'hFE20AE23, 32'h0000_0120, 1'b0, 5'd0, 32'd0);
        checkEq("swneg.ImmExtE", ImmExtE, 32'hFFFFFFFC);

        // jal x1,8
        issue(32'h008000EF, 32'h0000_0124, 1'b0, 5'd0, 32'd0);
        checkCtrl("jal", 32'd1, 32'd0, 32'd1, 32'd0);
        checkEq("jal.ResultSrcE", {30'd0, ResultSrcE}, 32'd2);
        checkEq("jal.ImmExtE", ImmExtE, 32'd8);

        // write to x0 is ignored, both during and after the write cycle
        issue(32'h00000333, 32'h0000_0128, 1'b1, 5'd0, 32'h00001234);
        checkEq("x0wr.RD1E", RD1E, 32'd0);
        issue(32'h00000333, 32'h0000_012C, 1'b0, 5'd0, 32'd0);
        checkEq("x0rd.RD1E", RD1E, 32'd0);

        // lw x5,8(x1), then stall two cycles with a different instruction
        issue(32'h0080A283, 32'h0000_0130, 1'b0, 5'd0, 32'd0);
        checkEq("lw.ResultSrcE", {30'd0, ResultSrcE}, 32'd1);
        checkEq("lw.ImmExtE", ImmExtE, 32'd8);
        checkEq("lw.RD1E", RD1E, 32'd5);
        StallE = 1'b1;
        issue(32'h002081B3, 32'h0000_0134, 1'b1, 5'd9, 32'h0000CAFE);
        issue(32'h002081B3, 32'h0000_0134, 1'b0, 5'd0, 32'd0);
        checkEq("stall.RdE", {27'd0, RdE}, 32'd5);
        checkEq("stall.ImmExtE", ImmExtE, 32'd8);
        checkEq("stall.ResultSrcE", {30'd0, ResultSrcE}, 32'd1);
        checkEq("stall.PCE", PCE, 32'h0000_0130);
        checkCtrl("stall", 32'd1, 32'd0, 32'd0, 32'd0);

        // flush wins over stall
        FlushE = 1'b1;
        issue(32'h0020A623, 32'h0000_0138, 1'b0, 5'd0, 32'd0);
        checkCtrl("flush", 32'd0, 32'd0, 32'd0, 32'd0);
        checkEq("flush.RdE", {27'd0, RdE}, 32'd0);
        FlushE = 1'b0;
        StallE = 1'b0;

        // x9 written during the stall is visible: add x10,x9,x0
        issue(32'h00048533, 32'h0000_013C, 1'b0, 5'd0, 32'd0);
        checkEq("stallwr.RD1E", RD1E, 32'h0000CAFE);

        // unsupported opcode decodes to nop
        issue(32'hFFFFFFFF, 32'h0000_0140, 1'b0, 5'd0, 32'd0);
        checkCtrl("illegal", 32'd0, 32'd0, 32'd0, 32'd0);
        checkEq("illegal.ALUSrcE", {31'd0, ALUSrcE}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkEq("illegal.IllegalE", {31'd0, IllegalE}, 32'd1);
`endif

        // reset mid-stream while a write to x11 is pending
        rst = 1'b1;
        issue(32'h00500093, 32'h0000_0144, 1'b1, 5'd11, 32'h00000055);
        rst = 1'b0;
        checkCtrl("midrst", 32'd0, 32'd0, 32'd0, 32'd0);
        checkEq("midrst.ImmExtE", ImmExtE, 32'd0);
        checkEq("midrst.PCE", PCE, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkEq("midrst.IllegalE", {31'd0, IllegalE}, 32'd0);
`endif
        // add x3,x1,x11 style read: x1 cleared, x11 write was lost (0x00B08533: add x10,x1,x11)
        issue(32'h00B08533, 32'h0000_0148, 1'b0, 5'd0, 32'd0);
        checkEq("postrst.RD1E", RD1E, 32'd0);
        checkEq("postrst.RD2E", RD2E, 32'd0);
        checkEq("postrst.Rs2E", {27'd0, Rs2E}, 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
